// File: rtl/spi_flash_pkg.sv
// Shared opcodes and FSM state encoding for the SPI flash stand-in.
package spi_flash_pkg;

  localparam logic [7:0] OP_PP   = 8'h02;
  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_WRDI = 8'h04;
  localparam logic [7:0] OP_RDSR = 8'h05;
  localparam logic [7:0] OP_WREN = 8'h06;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_RD,
    S_WR,
    S_STAT,
    S_IGNORE
  } state_t;

endpackage

// File: rtl/spi_input_sync.sv
// Two-flop synchronizer for one asynchronous SPI pin, with single-cycle rise/fall pulses.
module spi_input_sync (
  input  logic clk,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Left unreset so that reset never fabricates an edge on a pin that is
  // already held low (a fresh CS fall is required after reset).
  always_ff @(posedge clk) begin
    r_meta <= i_async;
    r_sync <= r_meta;
    r_prev <= r_sync;
  end

  assign o_level = r_sync;
  assign o_rise  = r_sync & ~r_prev;
  assign o_fall  = ~r_sync & r_prev;

endmodule

// File: rtl/spi_flash_target.sv
// SPI mode 0 flash emulator (READ / PAGE PROGRAM / WREN) over an internal byte array.
// Define SPI_FLASH_STATUS_EN to add READ STATUS (0x05) and WRITE DISABLE (0x04).
module spi_flash_target
  import spi_flash_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_SPI_CLK,
  input  logic                  i_SPI_MOSI,
  input  logic                  i_SPI_CS,
  output logic                  o_SPI_MISO,
  output logic                  o_MISO_OE,
  input  logic                  i_load_en,
  input  logic [ADDR_WIDTH-1:0] i_load_addr,
  input  logic [7:0]            i_load_data,
  output logic                  o_wel,
  output logic [2:0]            o_dbg_state
);

  localparam int MEM_DEPTH = 1 << ADDR_WIDTH;

  state_t                r_state, w_next_state;
  logic [2:0]            r_bit_cnt;
  logic [1:0]            r_byte_cnt;
  logic [6:0]            r_shift_in;
  logic [7:0]            r_opcode;
  logic [7:0]            r_shift_out;
  logic [7:0]            r_rd_data;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_wel, r_miso, r_miso_oe, r_load_pend;
  logic [7:0]            r_mem [MEM_DEPTH];

  logic w_sck_rise, w_sck_fall, w_unused_sck_level;
  logic w_cs_level, w_cs_rise, w_cs_fall;
  logic w_mosi, w_unused_mosi_rise, w_unused_mosi_fall;

  spi_input_sync u_sync_sck (.clk(clk), .i_async(i_SPI_CLK), .o_level(w_unused_sck_level),
                             .o_rise(w_sck_rise), .o_fall(w_sck_fall));
  spi_input_sync u_sync_cs (.clk(clk), .i_async(i_SPI_CS), .o_level(w_cs_level),
                            .o_rise(w_cs_rise), .o_fall(w_cs_fall));
  spi_input_sync u_sync_mosi (.clk(clk), .i_async(i_SPI_MOSI), .o_level(w_mosi),
                              .o_rise(w_unused_mosi_rise), .o_fall(w_unused_mosi_fall));

  logic [7:0]            w_byte, w_load_val;
  logic                  w_byte_done, w_addr_done, w_shifting, w_driving, w_next_driving;
  logic                  w_first_rd, w_prefetch, w_stat_load, w_prog;
  logic [ADDR_WIDTH-1:0] w_rd_addr;

  assign w_byte         = {r_shift_in, w_mosi};
  assign w_byte_done    = w_sck_rise && (r_bit_cnt == 3'd7);
  assign w_addr_done    = (r_state == S_ADDR) && w_byte_done && (r_byte_cnt == 2'd2);
  assign w_shifting     = (r_state == S_CMD) || (r_state == S_ADDR) || (r_state == S_WR);
  assign w_driving      = (r_state == S_RD) || (r_state == S_STAT);
  assign w_next_driving = (w_next_state == S_RD) || (w_next_state == S_STAT);
  assign w_first_rd     = w_addr_done && (r_opcode == OP_READ) && !w_cs_rise;
  // Bit 0 of the current byte is going out: fetch the following byte now.
  assign w_prefetch     = (r_state == S_RD) && w_sck_fall && (r_bit_cnt == 3'd7) && !w_cs_rise;
  assign w_stat_load    = ((r_state == S_CMD) && w_byte_done && (w_next_state == S_STAT)) ||
                          ((r_state == S_STAT) && w_sck_fall && (r_bit_cnt == 3'd7) && !w_cs_rise);
  assign w_prog         = (r_state == S_WR) && w_byte_done && !w_cs_rise && !reset;
  assign w_rd_addr      = w_first_rd ? {r_addr[ADDR_WIDTH-2:0], w_mosi} : r_addr + ADDR_WIDTH'(1);
  assign w_load_val     = (r_state == S_STAT) ? {6'b0, r_wel, 1'b0} : r_rd_data;

  always_comb begin
    w_next_state = r_state;
    if (w_cs_rise) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (w_cs_fall) w_next_state = S_CMD;
        S_CMD: begin
          if (w_byte_done) begin
            case (w_byte)
              OP_READ, OP_PP: w_next_state = S_ADDR;
`ifdef SPI_FLASH_STATUS_EN
              OP_RDSR:        w_next_state = S_STAT;
              OP_WRDI:        w_next_state = S_IGNORE;
`else
              OP_RDSR, OP_WRDI: w_next_state = S_IGNORE;
`endif
              default:        w_next_state = S_IGNORE;
            endcase
          end
        end
        S_ADDR: begin
          if (w_addr_done) begin
            if (r_opcode == OP_READ) w_next_state = S_RD;
            else if (r_wel)          w_next_state = S_WR;
            else                     w_next_state = S_IGNORE;
          end
        end
        default: w_next_state = r_state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= 3'd0;
      r_byte_cnt  <= 2'd0;
      r_shift_in  <= 7'd0;
      r_opcode    <= 8'd0;
      r_shift_out <= 8'd0;
      r_addr      <= '0;
      r_wel       <= 1'b0;
      r_miso      <= 1'b0;
      r_miso_oe   <= 1'b0;
      r_load_pend <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_load_pend <= w_first_rd || w_prefetch || w_stat_load;
      if (w_cs_rise) begin
        if (r_opcode == OP_PP) r_wel <= 1'b0;
      end else if (r_state == S_IDLE) begin
        if (w_cs_fall) begin
          r_bit_cnt  <= 3'd0;
          r_byte_cnt <= 2'd0;
          r_opcode   <= 8'd0;
        end
      end else begin
        if (w_sck_rise && w_shifting) begin
          r_bit_cnt  <= r_bit_cnt + 3'd1;
          r_shift_in <= w_byte[6:0];
        end
        if ((r_state == S_CMD) && w_byte_done) begin
          r_opcode <= w_byte;
          if (w_byte == OP_WREN) r_wel <= 1'b1;
`ifdef SPI_FLASH_STATUS_EN
          if (w_byte == OP_WRDI) r_wel <= 1'b0;
`endif
        end
        if ((r_state == S_ADDR) && w_sck_rise) begin
          r_addr <= {r_addr[ADDR_WIDTH-2:0], w_mosi};
          if (r_bit_cnt == 3'd7) r_byte_cnt <= r_byte_cnt + 2'd1;
        end
        // Program address wraps inside the 256-byte page.
        if (w_prog) r_addr <= {r_addr[ADDR_WIDTH-1:8], r_addr[7:0] + 8'd1};
        if (w_driving && w_sck_fall) begin
          r_bit_cnt   <= r_bit_cnt + 3'd1;
          r_miso      <= r_shift_out[7];
          r_shift_out <= {r_shift_out[6:0], 1'b0};
        end
        if (w_prefetch) r_addr <= r_addr + ADDR_WIDTH'(1);
      end
      if (r_load_pend) begin
        r_shift_out <= w_load_val;
        r_miso_oe   <= 1'b1;
      end
      if (!w_next_driving) begin
        r_miso    <= 1'b0;
        r_miso_oe <= 1'b0;
      end
    end
  end

  // i_load_en is a single-cycle write strobe with no ready: it takes effect
  // whenever synchronized CS is high and wins over a program write.
  always_ff @(posedge clk) begin
    if (i_load_en && w_cs_level) r_mem[i_load_addr] <= i_load_data;
    else if (w_prog)             r_mem[r_addr] <= r_mem[r_addr] & w_byte;
    if (w_first_rd || w_prefetch) r_rd_data <= r_mem[w_rd_addr];
  end

  assign o_SPI_MISO  = r_miso;
  assign o_MISO_OE   = r_miso_oe;
  assign o_wel       = r_wel;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_spi_flash_target.sv
// Self-checking bench for spi_flash_target: SPI master driver, flash model, expected-byte queue.
module tb_spi_flash_target;

  localparam int AW   = 12;
  localparam int HALF = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          sck = 1'b0;
  logic          mosi = 1'b0;
  logic          cs = 1'b1;
  logic          load_en = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [7:0]    load_data = '0;
  logic          miso, oe, wel;
  logic [2:0]    dbg_state;

  always #5 clk = ~clk;

  spi_flash_target #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .i_SPI_CLK(sck), .i_SPI_MOSI(mosi), .i_SPI_CS(cs),
    .o_SPI_MISO(miso), .o_MISO_OE(oe), .i_load_en(load_en), .i_load_addr(load_addr),
    .i_load_data(load_data), .o_wel(wel), .o_dbg_state(dbg_state)
  );

  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] m_mem [4096];
  bit         m_wel = 1'b0;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] pp_data[$];
  bit         oe_seen;
  logic       oe_after_cs;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  // ---------------- driver tasks ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic backdoor(input logic [11:0] a, input logic [7:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    wait_clk(1);
    load_en = 1'b0;
    m_mem[a] = d;
  endtask

  task automatic fill_erased();
    load_en = 1'b1;
    for (int i = 0; i < 4096; i++) begin
      load_addr = 12'(i); load_data = 8'hFF; m_mem[i] = 8'hFF;
      wait_clk(1);
    end
    load_en = 1'b0;
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = tx[i];
      wait_clk(HALF);
      rx[i] = miso;
      oe_seen |= oe;
      sck = 1'b1;
      wait_clk(HALF);
      sck = 1'b0;
    end
  endtask

  task automatic spi_xfer();
    logic [7:0] rx;
    rx_q.delete();
    oe_seen = 1'b0;
    cs = 1'b0;
    wait_clk(HALF);
    foreach (tx_q[k]) begin
      spi_bits(tx_q[k], 8, rx);
      rx_q.push_back(rx);
    end
    wait_clk(2);
    cs = 1'b1;
    wait_clk(4);
    oe_after_cs = oe;
    wait_clk(4);
    tx_q.delete();
  endtask

  task automatic push_addr(input logic [11:0] a);
    tx_q.push_back(8'($urandom_range(0, 255)));
    tx_q.push_back({4'($urandom_range(0, 15)), a[11:8]});
    tx_q.push_back(a[7:0]);
  endtask

  task automatic spi_read(input logic [11:0] a, input int n);
    tx_q.push_back(8'h03);
    push_addr(a);
    repeat (n) tx_q.push_back(8'($urandom_range(0, 255)));
    spi_xfer();
    repeat (4) rx_q.delete(0);
  endtask

  task automatic spi_pp(input logic [11:0] a);
    tx_q.push_back(8'h02);
    push_addr(a);
    foreach (pp_data[k]) tx_q.push_back(pp_data[k]);
    spi_xfer();
  endtask

  task automatic spi_cmd(input logic [7:0] op);
    tx_q.push_back(op);
    spi_xfer();
  endtask

  // ---------------- reference model ----------------
  task automatic model_read(input logic [11:0] a, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(m_mem[(int'(a) + k) % 4096]);
  endtask

  task automatic model_pp(input logic [11:0] a);
    int pa;
    if (m_wel) begin
      foreach (pp_data[k]) begin
        pa = (int'(a) / 256) * 256 + ((int'(a) + k) % 256);
        m_mem[pa] = m_mem[pa] & pp_data[k];
      end
    end
    m_wel = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    wait_clk(6);
    reset = 1'b0;
    wait_clk(2);
    n_checks++;
    if (miso !== 1'b0) begin n_fail++; $display("FAIL reset_miso: got %b expected 0", miso); end
    n_checks++;
    if (oe !== 1'b0) begin n_fail++; $display("FAIL reset_oe: got %b expected 0", oe); end
    n_checks++;
    if (wel !== 1'b0) begin n_fail++; $display("FAIL reset_wel: got %b expected 0", wel); end
  endtask

  task automatic test_read_basic();
    logic [7:0] exp;
    backdoor(12'h123, 8'hA5);
    backdoor(12'h124, 8'h3C);
    model_read(12'h123, 2);
    spi_read(12'h123, 2);
    for (int k = 0; k < 2; k++) begin
      exp = exp_q.pop_front();
      n_checks++;
      if (rx_q[k] !== exp) begin
        n_fail++; $display("FAIL read_basic byte %0d: got %h expected %h", k, rx_q[k], exp);
      end
    end
    n_checks++;
    if (oe_seen !== 1'b1) begin n_fail++; $display("FAIL read_oe_driven: got %b expected 1", oe_seen); end
    n_checks++;
    if (oe_after_cs !== 1'b0) begin n_fail++; $display("FAIL read_oe_release: got %b expected 0", oe_after_cs); end
  endtask

  task automatic test_pp_no_wel();
    logic [7:0] exp;
    pp_data = '{8'h55};
    model_pp(12'h010);
    spi_pp(12'h010);
    n_checks++;
    if (wel !== m_wel) begin n_fail++; $display("FAIL pp_no_wel_wel: got %b expected %b", wel, m_wel); end
    model_read(12'h010, 1);
    spi_read(12'h010, 1);
    exp = exp_q.pop_front();
    n_checks++;
    if (rx_q[0] !== exp) begin n_fail++; $display("FAIL pp_no_wel_mem: got %h expected %h", rx_q[0], exp); end
  endtask

  task automatic test_page_wrap();
    logic [7:0] exp;
    spi_cmd(8'h06);
    m_wel = 1'b1;
    n_checks++;
    if (wel !== m_wel) begin n_fail++; $display("FAIL wren_set: got %b expected %b", wel, m_wel); end
    pp_data = '{8'hAA, 8'h0F};
    model_pp(12'h0FF);
    spi_pp(12'h0FF);
    n_checks++;
    if (wel !== m_wel) begin n_fail++; $display("FAIL pp_wel_clear: got %b expected %b", wel, m_wel); end
    model_read(12'h0FF, 1);
    spi_read(12'h0FF, 1);
    exp = exp_q.pop_front();
    n_checks++;
    if (rx_q[0] !== exp) begin n_fail++; $display("FAIL page_wrap_0ff: got %h expected %h", rx_q[0], exp); end
    model_read(12'h000, 1);
    spi_read(12'h000, 1);
    exp = exp_q.pop_front();
    n_checks++;
    if (rx_q[0] !== exp) begin n_fail++; $display("FAIL page_wrap_000: got %h expected %h", rx_q[0], exp); end
  endtask

  task automatic test_and_and_wrap();
    logic [7:0] exp;
    backdoor(12'h200, 8'h3C);
    spi_cmd(8'h06);
    m_wel = 1'b1;
    pp_data = '{8'hF0};
    model_pp(12'h200);
    spi_pp(12'h200);
    model_read(12'h200, 1);
    spi_read(12'h200, 1);
    exp = exp_q.pop_front();
    n_checks++;
    if (rx_q[0] !== exp) begin n_fail++; $display("FAIL and_semantics: got %h expected %h", rx_q[0], exp); end
    backdoor(12'hFFF, 8'h5A);
    model_read(12'hFFF, 2);
    spi_read(12'hFFF, 2);
    for (int k = 0; k < 2; k++) begin
      exp = exp_q.pop_front();
      n_checks++;
      if (rx_q[k] !== exp) begin
        n_fail++; $display("FAIL read_addr_wrap byte %0d: got %h expected %h", k, rx_q[k], exp);
      end
    end
  endtask

  task automatic test_abort();
    logic [7:0] rx, exp;
    spi_cmd(8'h06);
    cs = 1'b0;
    wait_clk(HALF);
    spi_bits(8'h02, 8, rx);
    spi_bits(8'h00, 8, rx);
    spi_bits(8'h03, 8, rx);
    spi_bits(8'h00, 8, rx);
    spi_bits(8'h00, 4, rx);
    wait_clk(2);
    cs = 1'b1;
    wait_clk(8);
    m_wel = 1'b0;
    n_checks++;
    if (wel !== m_wel) begin n_fail++; $display("FAIL abort_wel: got %b expected %b", wel, m_wel); end
    model_read(12'h300, 1);
    spi_read(12'h300, 1);
    exp = exp_q.pop_front();
    n_checks++;
    if (rx_q[0] !== exp) begin n_fail++; $display("FAIL abort_mem: got %h expected %h", rx_q[0], exp); end
  endtask

  task automatic test_ignore();
    tx_q = '{8'hAB, 8'h00, 8'h00, 8'h00, 8'h00};
    spi_xfer();
    n_checks++;
    if (oe_seen !== 1'b0) begin n_fail++; $display("FAIL ignore_oe: got %b expected 0", oe_seen); end
    n_checks++;
    if (rx_q[4] !== 8'h00) begin n_fail++; $display("FAIL ignore_miso: got %h expected 00", rx_q[4]); end
  endtask

  task automatic test_status();
`ifdef SPI_FLASH_STATUS_EN
    logic [7:0] exp;
    spi_cmd(8'h06);
    m_wel = 1'b1;
    tx_q = '{8'h05, 8'h00, 8'h00};
    spi_xfer();
    exp = {6'b0, m_wel, 1'b0};
    for (int k = 1; k < 3; k++) begin
      n_checks++;
      if (rx_q[k] !== exp) begin n_fail++; $display("FAIL rdsr_wel1 byte %0d: got %h expected %h", k, rx_q[k], exp); end
    end
    spi_cmd(8'h04);
    m_wel = 1'b0;
    n_checks++;
    if (wel !== m_wel) begin n_fail++; $display("FAIL wrdi_wel: got %b expected %b", wel, m_wel); end
    tx_q = '{8'h05, 8'h00};
    spi_xfer();
    exp = {6'b0, m_wel, 1'b0};
    n_checks++;
    if (rx_q[1] !== exp) begin n_fail++; $display("FAIL rdsr_wel0: got %h expected %h", rx_q[1], exp); end
`else
    spi_cmd(8'h06);
    m_wel = 1'b1;
    tx_q = '{8'h05, 8'h00, 8'h00};
    spi_xfer();
    n_checks++;
    if (oe_seen !== 1'b0) begin n_fail++; $display("FAIL rdsr_disabled_oe: got %b expected 0", oe_seen); end
    spi_cmd(8'h04);
    n_checks++;
    if (wel !== m_wel) begin n_fail++; $display("FAIL wrdi_disabled_wel: got %b expected %b", wel, m_wel); end
`endif
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] rx, exp;
    spi_cmd(8'h06);
    m_wel = 1'b1;
    backdoor(12'h050, 8'h81);
    cs = 1'b0;
    wait_clk(HALF);
    spi_bits(8'h03, 8, rx);
    spi_bits(8'h00, 8, rx);
    spi_bits(8'h00, 8, rx);
    spi_bits(8'h50, 8, rx);
    spi_bits(8'h00, 3, rx);
    n_checks++;
    if (oe !== 1'b1) begin n_fail++; $display("FAIL mid_read_oe: got %b expected 1", oe); end
    reset = 1'b1;
    wait_clk(2);
    m_wel = 1'b0;
    n_checks++;
    if (miso !== 1'b0) begin n_fail++; $display("FAIL midrst_miso: got %b expected 0", miso); end
    n_checks++;
    if (oe !== 1'b0) begin n_fail++; $display("FAIL midrst_oe: got %b expected 0", oe); end
    n_checks++;
    if (wel !== m_wel) begin n_fail++; $display("FAIL midrst_wel: got %b expected %b", wel, m_wel); end
    reset = 1'b0;
    wait_clk(2);
    // CS is still low: a WREN byte without a fresh CS fall must be ignored.
    spi_bits(8'h06, 8, rx);
    wait_clk(4);
    n_checks++;
    if (wel !== m_wel) begin n_fail++; $display("FAIL no_fresh_fall_wel: got %b expected %b", wel, m_wel); end
    cs = 1'b1;
    wait_clk(8);
    model_read(12'h050, 1);
    spi_read(12'h050, 1);
    exp = exp_q.pop_front();
    n_checks++;
    if (rx_q[0] !== exp) begin n_fail++; $display("FAIL post_reset_read: got %h expected %h", rx_q[0], exp); end
  endtask

  task automatic test_random();
    logic [11:0] a;
    logic [7:0]  exp;
    int          kind, n;
    for (int it = 0; it < 24; it++) begin
      kind = $urandom_range(0, 3);
      a = 12'($urandom_range(0, 4095));
      if ($urandom_range(0, 3) == 0) a[7:0] = 8'hFE;
      n = $urandom_range(1, 4);
      case (kind)
        0: ;
        1: begin
          spi_cmd(8'h06);
          m_wel = 1'b1;
          pp_data.delete();
          repeat (n) pp_data.push_back(8'($urandom_range(0, 255)));
          model_pp(a);
          spi_pp(a);
        end
        2: begin
          pp_data = '{8'($urandom_range(0, 255))};
          model_pp(a);
          spi_pp(a);
        end
        default: backdoor(a, 8'($urandom_range(0, 255)));
      endcase
      n_checks++;
      if (wel !== m_wel) begin n_fail++; $display("FAIL rand_wel it %0d: got %b expected %b", it, wel, m_wel); end
      model_read(a, n);
      spi_read(a, n);
      for (int k = 0; k < n; k++) begin
        exp = exp_q.pop_front();
        n_checks++;
        if (rx_q[k] !== exp) begin
          n_fail++;
          $display("FAIL rand_read it %0d addr %h byte %0d: got %h expected %h", it, a, k, rx_q[k], exp);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    fill_erased();
    test_read_basic();
    test_pp_no_wel();
    test_page_wrap();
    test_and_and_wrap();
    test_abort();
    test_ignore();
    test_status();
    test_reset_mid_read();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
